// File: rtl/pcie_bridge_pkg.sv
// Shared constants for the PCIe Avalon-ST <-> TRN bridges: FIFO word layout,
// TLP fmt/type codes that carry swapped byte enables, and the RX output FSM states.
package pcie_bridge_pkg;

    localparam int SOP_BIT = 73;
    localparam int EOP_BIT = 72;
    localparam int BE_MSB  = 71;
    localparam int BE_LSB  = 64;

    localparam logic [7:0] MRD32 = 8'h00;
    localparam logic [7:0] MRD64 = 8'h20;
    localparam logic [7:0] MWR32 = 8'h40;
    localparam logic [7:0] MWR64 = 8'h60;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_ROUT = 2'd1,
        S_DONE = 2'd2
    } rx_state_e;

    function automatic logic [3:0] rev4(input logic [3:0] v);
        return {v[0], v[1], v[2], v[3]};
    endfunction

    function automatic logic is_mem_req(input logic [7:0] fmt_type);
        return (fmt_type == MRD32) || (fmt_type == MRD64) ||
               (fmt_type == MWR32) || (fmt_type == MWR64);
    endfunction

endpackage

// File: rtl/rx_avalon_to_trn_if.sv
// Avalon-ST RX sink and TRN RX source signals of the receive bridge.
// The master modport is the bridge side; slave is the hard IP / user side.
interface rx_avalon_to_trn_if;
    logic [63:0] rx_st_data0;
    logic [7:0]  rx_st_be0;
    logic        rx_st_sop0;
    logic        rx_st_eop0;
    logic        rx_st_valid0;
    logic        rx_st_ready0;

    logic [63:0] trn_rd;
    logic        trn_rrem;
    logic        trn_rsof;
    logic        trn_reof;
    logic        trn_rsrc_rdy;
    logic        trn_rdst_rdy;

    modport master (
        input  rx_st_data0, rx_st_be0, rx_st_sop0, rx_st_eop0, rx_st_valid0,
        output rx_st_ready0,
        output trn_rd, trn_rrem, trn_rsof, trn_reof, trn_rsrc_rdy,
        input  trn_rdst_rdy
    );

    modport slave (
        output rx_st_data0, rx_st_be0, rx_st_sop0, rx_st_eop0, rx_st_valid0,
        input  rx_st_ready0,
        input  trn_rd, trn_rrem, trn_rsof, trn_reof, trn_rsrc_rdy,
        output trn_rdst_rdy
    );
endinterface

// File: rtl/fifo.sv
// Synchronous show-ahead FIFO: q shows the head word whenever empty is low.
// RAM read is registered at the next read address, with a bypass for a write into that slot.
module fifo #(
    parameter int DATA_W  = 74,
    parameter int DEPTH_W = 10
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [DATA_W-1:0] data,
    input  logic              wrreq,
    input  logic              rdreq,
    output logic [DATA_W-1:0] q,
    output logic              empty,
    output logic              full,
    output logic [DEPTH_W-1:0] usedw
);
    localparam int DEPTH = 1 << DEPTH_W;

    logic [DATA_W-1:0]  mem [DEPTH];
    logic [DATA_W-1:0]  ram_q;
    logic [DATA_W-1:0]  byp_data_q;
    logic               byp_sel_q;
    logic [DEPTH_W-1:0] wr_ptr_q;
    logic [DEPTH_W-1:0] rd_ptr_q;
    logic [DEPTH_W-1:0] rd_addr_next;
    logic [DEPTH_W:0]   count_q;
    logic               wr_en;
    logic               rd_en;

    assign empty        = (count_q == '0);
    assign full         = count_q[DEPTH_W];
    assign usedw        = count_q[DEPTH_W-1:0];
    assign wr_en        = wrreq & ~full;
    assign rd_en        = rdreq & ~empty;
    assign rd_addr_next = rd_ptr_q + DEPTH_W'(rd_en);
    assign q            = byp_sel_q ? byp_data_q : ram_q;

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_ptr_q] <= data;
        end
        ram_q      <= mem[rd_addr_next];
        byp_data_q <= data;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            count_q   <= '0;
            byp_sel_q <= 1'b0;
        end else begin
            // A write landing on the slot about to be shown must bypass the RAM read.
            byp_sel_q <= wr_en && (wr_ptr_q == rd_addr_next);
            rd_ptr_q  <= rd_addr_next;
            if (wr_en) begin
                wr_ptr_q <= wr_ptr_q + 1'b1;
            end
            case ({wr_en, rd_en})
                2'b10:   count_q <= count_q + 1'b1;
                2'b01:   count_q <= count_q - 1'b1;
                default: count_q <= count_q;
            endcase
        end
    end
endmodule

// File: rtl/rx_avalon_to_trn.sv
// Receive bridge: stores Avalon-ST RX beats in a packet-mode FIFO and replays each
// complete TLP as one gap-free TRN burst, undoing the TX-side byte-enable nibble swap.
module rx_avalon_to_trn
    import pcie_bridge_pkg::*;
#(
    parameter int AXI_DATA_WIDTH  = 64,
    parameter int FIFO_DEPTH      = 10,
    parameter int FIFO_DATA_WIDTH = 74
) (
    input  logic               axi_clk,
    input  logic               axi_rst_n,
    rx_avalon_to_trn_if.master bus,
    output logic               rx_err
);
    logic [AXI_DATA_WIDTH-1:0]  beat_data;
    logic [FIFO_DATA_WIDTH-1:0] wr_word;
    logic [FIFO_DATA_WIDTH-1:0] q;
    logic                       empty;
    logic                       full;
    logic [FIFO_DEPTH-1:0]      usedw;

    logic                       wr_en;
    logic                       drop;
    logic                       rd_req;
    logic                       eop_wr;
    logic                       eop_rd;
    logic                       launch;
    logic                       head_discard;
    logic                       in_pkt_q, in_pkt_d;
    logic [FIFO_DEPTH:0]        pkt_cnt_q, pkt_cnt_d;
    logic                       ready_q;
    logic                       err_q;
    logic                       src_rdy_q;
    rx_state_e                  state_q;
    logic                       unused_bits;

    always_comb begin
        beat_data = bus.rx_st_data0;
        if (bus.rx_st_sop0 && is_mem_req(bus.rx_st_data0[31:24])) begin
            beat_data[35:32] = rev4(bus.rx_st_data0[35:32]);
            beat_data[39:36] = rev4(bus.rx_st_data0[39:36]);
        end
    end

    assign wr_word = {bus.rx_st_sop0, bus.rx_st_eop0, bus.rx_st_be0, beat_data};
    assign wr_en   = bus.rx_st_valid0 && (bus.rx_st_sop0 || in_pkt_q) && !full;
    assign drop    = bus.rx_st_valid0 && ((!bus.rx_st_sop0 && !in_pkt_q) || full);
    assign eop_wr  = wr_en && bus.rx_st_eop0;

    always_comb begin
        in_pkt_d = in_pkt_q;
        if (wr_en) begin
            in_pkt_d = bus.rx_st_eop0 ? 1'b0 : (bus.rx_st_sop0 ? 1'b1 : in_pkt_q);
        end
    end

    // Only a head that starts a fully stored packet may launch a burst.
    assign launch       = !empty && q[SOP_BIT] && (pkt_cnt_q != '0);
    assign head_discard = (state_q == S_IDLE) && !empty && !q[SOP_BIT];
    assign rd_req       = ((state_q == S_ROUT) && bus.trn_rdst_rdy && !empty) || head_discard;
    assign eop_rd       = rd_req && q[EOP_BIT];

    always_comb begin
        pkt_cnt_d = pkt_cnt_q;
        if (eop_wr && !eop_rd) begin
            pkt_cnt_d = pkt_cnt_q + 1'b1;
        end else if (!eop_wr && eop_rd) begin
            pkt_cnt_d = pkt_cnt_q - 1'b1;
        end
    end

    fifo #(
        .DATA_W  (FIFO_DATA_WIDTH),
        .DEPTH_W (FIFO_DEPTH)
    ) u_fifo (
        .clk   (axi_clk),
        .rst_n (axi_rst_n),
        .data  (wr_word),
        .wrreq (wr_en),
        .rdreq (rd_req),
        .q     (q),
        .empty (empty),
        .full  (full),
        .usedw (usedw)
    );

    always_ff @(posedge axi_clk or negedge axi_rst_n) begin
        if (!axi_rst_n) begin
            in_pkt_q  <= 1'b0;
            pkt_cnt_q <= '0;
            ready_q   <= 1'b0;
            err_q     <= 1'b0;
        end else begin
            in_pkt_q  <= in_pkt_d;
            pkt_cnt_q <= pkt_cnt_d;
            ready_q   <= ~usedw[FIFO_DEPTH-1];
            err_q     <= drop || head_discard;
        end
    end

    // S_DONE is the mandatory gap cycle; it may launch the next stored packet
    // directly so back-to-back TLPs are separated by exactly one idle cycle.
    always_ff @(posedge axi_clk or negedge axi_rst_n) begin
        if (!axi_rst_n) begin
            state_q   <= S_IDLE;
            src_rdy_q <= 1'b0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (launch) begin
                        state_q   <= S_ROUT;
                        src_rdy_q <= 1'b1;
                    end
                end
                S_ROUT: begin
                    if (rd_req && q[EOP_BIT]) begin
                        state_q   <= S_DONE;
                        src_rdy_q <= 1'b0;
                    end
                end
                S_DONE: begin
                    state_q   <= launch ? S_ROUT : S_IDLE;
                    src_rdy_q <= launch;
                end
                default: begin
                    state_q   <= S_IDLE;
                    src_rdy_q <= 1'b0;
                end
            endcase
        end
    end

    assign bus.rx_st_ready0 = ready_q;
    assign bus.trn_rsrc_rdy = src_rdy_q;
    assign bus.trn_rd       = src_rdy_q ? q[AXI_DATA_WIDTH-1:0] : '0;
    assign bus.trn_rsof     = src_rdy_q & q[SOP_BIT];
    assign bus.trn_reof     = src_rdy_q & q[EOP_BIT];
    assign bus.trn_rrem     = src_rdy_q & (|q[BE_MSB:BE_MSB-3]);
    assign rx_err           = err_q;

    assign unused_bits = ^{q[BE_LSB+3:BE_LSB], usedw[FIFO_DEPTH-2:0]};
endmodule

// File: tb/tb_rx_avalon_to_trn.sv
// Directed bench for rx_avalon_to_trn: a negedge monitor records accepted TRN beats,
// and every expectation below is a hand-computed constant.
module tb_rx_avalon_to_trn;
    typedef struct {
        logic [63:0] d;
        logic        sof;
        logic        eof;
        logic        rem;
        int          cyc;
    } beat_t;

    logic  clk = 1'b0;
    logic  rst_n = 1'b0;
    logic  rx_err;
    int    total = 0;
    int    bad = 0;
    int    cyc_cnt = 0;
    int    err_cnt = 0;
    beat_t cap_q[$];

    rx_avalon_to_trn_if bus ();

    rx_avalon_to_trn dut (
        .axi_clk   (clk),
        .axi_rst_n (rst_n),
        .bus       (bus),
        .rx_err    (rx_err)
    );

    initial forever #5 clk = ~clk;

    always @(negedge clk) begin
        cyc_cnt <= cyc_cnt + 1;
        if (rst_n && rx_err) err_cnt <= err_cnt + 1;
        if (rst_n && bus.trn_rsrc_rdy && bus.trn_rdst_rdy)
            cap_q.push_back('{bus.trn_rd, bus.trn_rsof, bus.trn_reof, bus.trn_rrem, cyc_cnt});
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%h exp=%h", tag, got, exp);
        end else begin
            $display("ok   %s: %h", tag, got);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic send_beat(input logic [63:0] d, input logic [7:0] be, input logic sop, input logic eop);
        bus.rx_st_data0  = d;
        bus.rx_st_be0    = be;
        bus.rx_st_sop0   = sop;
        bus.rx_st_eop0   = eop;
        bus.rx_st_valid0 = 1'b1;
        step();
    endtask

    task automatic idle_in();
        bus.rx_st_valid0 = 1'b0;
        bus.rx_st_sop0   = 1'b0;
        bus.rx_st_eop0   = 1'b0;
    endtask

    task automatic wait_caps(input string tag, input int n, input int budget);
        int k = 0;
        while (cap_q.size() < n && k < budget) begin
            step();
            k++;
        end
        check(tag, cap_q.size(), n);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, required finish before time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        int base;
        int err0;
        int first_zero;
        int n;
        int k;
        logic [63:0] p3 [4];

        idle_in();
        bus.rx_st_data0  = '0;
        bus.rx_st_be0    = '0;
        bus.trn_rdst_rdy = 1'b1;
        repeat (3) step();

        // Reset state
        check("rst_ready", bus.rx_st_ready0, 0);
        check("rst_srcrdy", bus.trn_rsrc_rdy, 0);
        check("rst_rd", bus.trn_rd, 0);
        check("rst_err", rx_err, 0);
        rst_n = 1'b1;
        step();
        check("rel_ready", bus.rx_st_ready0, 1);

        // 1: MWr32 header, BE byte 1F -> 8F; non-sop beat with 00 top byte unchanged
        base = cap_q.size();
        send_beat(64'h0000_001F_4000_0001, 8'hFF, 1, 0);
        send_beat(64'h0000_001F_0000_0000, 8'hFF, 0, 0);
        send_beat(64'h5555_6666_7777_8888, 8'h0F, 0, 1);
        idle_in();
        wait_caps("t1_count", base + 3, 30);
        if (cap_q.size() >= base + 3) begin
            check("t1_d0", cap_q[base].d, 64'h0000_008F_4000_0001);
            check("t1_sof0", cap_q[base].sof, 1);
            check("t1_eof0", cap_q[base].eof, 0);
            check("t1_d1", cap_q[base+1].d, 64'h0000_001F_0000_0000);
            check("t1_d2", cap_q[base+2].d, 64'h5555_6666_7777_8888);
            check("t1_eof2", cap_q[base+2].eof, 1);
            check("t1_rem0", cap_q[base].rem, 1);
            check("t1_rem2", cap_q[base+2].rem, 0);
            check("t1_contig", cap_q[base+2].cyc - cap_q[base].cyc, 2);
        end
        repeat (4) step();

        // 2: completion 4A not swapped; MRd64 BE 36 -> C6
        base = cap_q.size();
        send_beat(64'h0000_001F_4A00_0001, 8'hFF, 1, 0);
        send_beat(64'h0123_4567_89AB_CDEF, 8'h0F, 0, 1);
        send_beat(64'h0000_0036_2000_0004, 8'hFF, 1, 1);
        idle_in();
        wait_caps("t2_count", base + 3, 30);
        if (cap_q.size() >= base + 3) begin
            check("t2_cpl_d0", cap_q[base].d, 64'h0000_001F_4A00_0001);
            check("t2_cpl_rem1", cap_q[base+1].rem, 0);
            check("t2_mrd_d0", cap_q[base+2].d, 64'h0000_00C6_2000_0004);
            check("t2_mrd_sofeof", {cap_q[base+2].sof, cap_q[base+2].eof}, 2'b11);
        end
        repeat (4) step();

        // 3: stall for 5 cycles mid-TLP
        base = cap_q.size();
        p3[0] = 64'h0000_000F_4000_0010;
        p3[1] = 64'hA1A1_A1A1_B2B2_B2B2;
        p3[2] = 64'hC3C3_C3C3_D4D4_D4D4;
        p3[3] = 64'hE5E5_E5E5_F6F6_F6F6;
        bus.trn_rdst_rdy = 1'b0;
        for (int i = 0; i < 4; i++) send_beat(p3[i], 8'hFF, (i == 0), (i == 3));
        idle_in();
        k = 0;
        while (!bus.trn_rsrc_rdy && k < 20) begin
            step();
            k++;
        end
        check("t3_srcrdy", bus.trn_rsrc_rdy, 1);
        check("t3_rd0", bus.trn_rd, p3[0]);
        check("t3_sof0", bus.trn_rsof, 1);
        bus.trn_rdst_rdy = 1'b1;
        step();
        bus.trn_rdst_rdy = 1'b0;
        for (int i = 0; i < 5; i++) begin
            check($sformatf("t3_hold%0d", i), bus.trn_rd, p3[1]);
            step();
        end
        check("t3_hold_flags", {bus.trn_rsof, bus.trn_reof, bus.trn_rsrc_rdy}, 3'b001);
        bus.trn_rdst_rdy = 1'b1;
        wait_caps("t3_count", base + 4, 20);
        if (cap_q.size() >= base + 4) begin
            for (int i = 0; i < 4; i++) check($sformatf("t3_d%0d", i), cap_q[base+i].d, p3[i]);
        end
        repeat (5) step();
        check("t3_nodup", cap_q.size(), base + 4);
        check("t3_pktcnt", dut.pkt_cnt_q, 0);

        // 4: eight 1-beat TLPs back to back -> exactly one idle cycle between frames
        base = cap_q.size();
        for (int i = 0; i < 8; i++) send_beat({32'hB000_0000 + i, 32'h0300_0000 + i}, 8'hFF, 1, 1);
        idle_in();
        wait_caps("t4_count", base + 8, 60);
        if (cap_q.size() >= base + 8) begin
            for (int i = 0; i < 8; i++) begin
                check($sformatf("t4_d%0d", i), cap_q[base+i].d, {32'hB000_0000 + i, 32'h0300_0000 + i});
                check($sformatf("t4_sofeof%0d", i), {cap_q[base+i].sof, cap_q[base+i].eof}, 2'b11);
                if (i > 0) check($sformatf("t4_gap%0d", i), cap_q[base+i].cyc - cap_q[base+i-1].cyc, 2);
            end
        end
        repeat (4) step();

        // 5: fill past half depth with the user stalled
        base = cap_q.size();
        err0 = err_cnt;
        first_zero = 0;
        n = 0;
        bus.trn_rdst_rdy = 1'b0;
        while (n < 600) begin
            n++;
            send_beat({32'hAB00_0000, 32'h0100_0000 + n}, 8'hFF, 1, 1);
            if (first_zero == 0 && !bus.rx_st_ready0) first_zero = n;
            if (first_zero != 0 && n == first_zero + 2) break;
        end
        idle_in();
        check("t5_ready_drop_at", first_zero, 513);
        step();
        check("t5_no_err", err_cnt - err0, 0);
        bus.trn_rdst_rdy = 1'b1;
        wait_caps("t5_count", base + 515, 1500);
        if (cap_q.size() >= base + 515) begin
            check("t5_first", cap_q[base].d, 64'hAB00_0000_0100_0001);
            check("t5_last", cap_q[base+514].d, 64'hAB00_0000_0100_0203);
        end
        repeat (4) step();

        // 6: stray beat, then reset mid-TLP
        base = cap_q.size();
        err0 = err_cnt;
        send_beat(64'h1234_5678_9ABC_DEF0, 8'hFF, 0, 0);
        check("t6_err_pulse", rx_err, 1);
        idle_in();
        step();
        check("t6_err_clear", rx_err, 0);
        repeat (8) step();
        check("t6_nothing_out", cap_q.size(), base);
        check("t6_err_count", err_cnt - err0, 1);

        bus.trn_rdst_rdy = 1'b0;
        send_beat(64'h0000_0000_0500_0000, 8'hFF, 1, 0);
        send_beat(64'h7777_7777_7777_7777, 8'hFF, 0, 1);
        send_beat(64'h0000_0000_0600_0000, 8'hFF, 1, 0);
        send_beat(64'h8888_8888_8888_8888, 8'hFF, 0, 0);
        idle_in();
        k = 0;
        while (!bus.trn_rsrc_rdy && k < 20) begin
            step();
            k++;
        end
        check("t6_pre_srcrdy", bus.trn_rsrc_rdy, 1);
        #2;
        rst_n = 1'b0;
        #1;
        check("t6_rst_srcrdy", bus.trn_rsrc_rdy, 0);
        check("t6_rst_rd", bus.trn_rd, 0);
        check("t6_rst_flags", {bus.trn_rsof, bus.trn_reof, bus.trn_rrem, rx_err}, 4'b0000);
        check("t6_rst_ready", bus.rx_st_ready0, 0);
        step();
        rst_n = 1'b1;
        bus.trn_rdst_rdy = 1'b1;
        step();
        check("t6_rel_ready", bus.rx_st_ready0, 1);
        err0 = err_cnt;
        send_beat(64'h9999_9999_9999_9999, 8'hFF, 0, 0);
        send_beat(64'hAAAA_AAAA_AAAA_AAAA, 8'h0F, 0, 1);
        idle_in();
        repeat (10) step();
        check("t6_flushed", cap_q.size(), base);
        check("t6_tail_dropped", err_cnt - err0, 2);
        send_beat(64'h0000_0000_0700_0042, 8'hFF, 1, 1);
        idle_in();
        wait_caps("t6_fresh_count", base + 1, 20);
        if (cap_q.size() >= base + 1) check("t6_fresh_d", cap_q[base].d, 64'h0000_0000_0700_0042);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
